// File: rtl/cond_eval_pipe_pkg.sv
// Shared definitions for the condition-evaluation pipeline: condition codes,
// NZCV flag bit positions and the output-stage state type.
package cond_eval_pipe_pkg;

  localparam int COND_LEN_DEF = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/cond_eval_pipe_cond_decode.sv
// Purely combinational ARM condition-code decode against an NZCV flag nibble.
module cond_decode
  import cond_eval_pipe_pkg::*;
#(
  parameter int COND_LEN = COND_LEN_DEF
) (
  input  logic [COND_LEN-1:0] cond,
  input  logic [3:0]          flags,
  output logic                pass
);

  logic n, z, c, v;
  cond_t code;

  assign n    = flags[FLAG_N];
  assign z    = flags[FLAG_Z];
  assign c    = flags[FLAG_C];
  assign v    = flags[FLAG_V];
  assign code = cond_t'(cond[3:0]);

  always_comb begin
    pass = 1'b0;
    unique case (code)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_eval_pipe.sv
// Banked NZCV status registers feeding a one-entry condition-evaluation
// output stage with valid/ready handshake, flush and saturating statistics.
module cond_eval_pipe
  import cond_eval_pipe_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  parameter  int CNT_W     = 16,
  parameter  int COND_LEN  = COND_LEN_DEF,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flag_wr_en,
  input  logic [BANK_W-1:0]   flag_wr_bank,
  input  logic [3:0]          flag_wr_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COND_LEN-1:0] in_cond,
  input  logic [BANK_W-1:0]   in_bank,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_pass,
  output logic [3:0]          out_flags,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt
);

  logic [3:0]       bank_q [NUM_BANKS];
  out_state_t       state_q, state_d;
  logic             pass_q, pass_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  logic       bank_ok;
  logic [3:0] stored_flags;
  logic [3:0] eval_flags;
  logic       dec_pass;
  logic       accept;
  logic       deliver;

  // Bank lookup by loop avoids out-of-range indexing when NUM_BANKS is not a power of two.
  always_comb begin
    bank_ok      = 1'b0;
    stored_flags = 4'b0000;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (in_bank == BANK_W'(b)) begin
        bank_ok      = 1'b1;
        stored_flags = bank_q[b];
      end
    end
    if (!bank_ok)
      eval_flags = 4'b0000;
    else if (flag_wr_en && (flag_wr_bank == in_bank))
      eval_flags = flag_wr_data;
    else
      eval_flags = stored_flags;
  end

  cond_decode #(.COND_LEN(COND_LEN)) u_cond_decode (
    .cond  (in_cond),
    .flags (eval_flags),
    .pass  (dec_pass)
  );

  assign in_ready = !flush && ((state_q == ST_EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;
  // A flushed result is discarded, so it never reaches the statistics.
  assign deliver  = (state_q == ST_FULL) && out_ready && !flush;

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    flags_d    = flags_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (flush)
      state_d = ST_EMPTY;
    else if (accept)
      state_d = ST_FULL;
    else if (deliver)
      state_d = ST_EMPTY;
    if (accept) begin
      pass_d  = dec_pass & bank_ok;
      flags_d = eval_flags;
    end
    if (deliver) begin
      if (pass_q && (pass_cnt_q != {CNT_W{1'b1}}))
        pass_cnt_d = pass_cnt_q + CNT_W'(1);
      if (!pass_q && (fail_cnt_q != {CNT_W{1'b1}}))
        fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      pass_q     <= 1'b0;
      flags_q    <= 4'b0000;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= 4'b0000;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      flags_q    <= flags_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (flag_wr_en && (flag_wr_bank == BANK_W'(b))) bank_q[b] <= flag_wr_data;
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_pass  = pass_q;
  assign out_flags = flags_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_cond_eval_pipe.sv
// Bench for cond_eval_pipe: table-driven code sweep, directed handshake and
// flush/reset sequences, a small-parameter instance, and a randomized run.
module tb_cond_eval_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_wr_en = 0, a_wr_bank = 0, a_in_valid = 0, a_in_bank = 0;
  logic        a_flush = 0, a_out_ready = 0;
  logic [3:0]  a_wr_data = 0, a_in_cond = 0;
  logic        a_in_ready, a_out_valid, a_out_pass;
  logic [3:0]  a_out_flags;
  logic [15:0] a_pass_cnt, a_fail_cnt;

  cond_eval_pipe dut_a (
    .clk(clk), .rst(rst),
    .flag_wr_en(a_wr_en), .flag_wr_bank(a_wr_bank), .flag_wr_data(a_wr_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_cond(a_in_cond), .in_bank(a_in_bank),
    .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pass(a_out_pass), .out_flags(a_out_flags),
    .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt)
  );

  // Instance B: three banks, 2-bit counters
  logic       b_wr_en = 0, b_in_valid = 0, b_flush = 0, b_out_ready = 0;
  logic [1:0] b_wr_bank = 0, b_in_bank = 0;
  logic [3:0] b_wr_data = 0, b_in_cond = 0;
  logic       b_in_ready, b_out_valid, b_out_pass;
  logic [3:0] b_out_flags;
  logic [1:0] b_pass_cnt, b_fail_cnt;

  cond_eval_pipe #(.NUM_BANKS(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .flag_wr_en(b_wr_en), .flag_wr_bank(b_wr_bank), .flag_wr_data(b_wr_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_cond(b_in_cond), .in_bank(b_in_bank),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pass(b_out_pass), .out_flags(b_out_flags),
    .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [3:0] cond;
    logic       exp_pass;
  } vec_t;

  typedef struct {
    logic       pass;
    logic [3:0] flags;
  } res_t;

  vec_t sweep[16];
  logic [15:0] sweep_bits;

  // reference model state for the randomized run
  res_t       m_q[$];
  logic [3:0] m_bank[2];
  int         m_pass, m_fail;

  initial begin
    sweep_bits = 16'b0110_0110_1010_1001;
    for (int i = 0; i < 16; i++) begin
      sweep[i].cond     = 4'(i);
      sweep[i].exp_pass = sweep_bits[i];
    end

    // reset state
    step(); step();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_pass_cnt", a_pass_cnt, 0);
    chk("rst_fail_cnt", a_fail_cnt, 0);
    chk("rst_out_flags", a_out_flags, 0);
    rst = 0;
    step();
    chk("idle_in_ready", a_in_ready, 1);

    // code sweep with bank0 = Z
    a_wr_en = 1; a_wr_bank = 0; a_wr_data = 4'b0100;
    step();
    a_wr_en = 0; a_out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1; a_in_cond = sweep[i].cond; a_in_bank = 0;
      #1 chk("sweep_in_ready", a_in_ready, 1);
      step();
      chk("sweep_out_valid", a_out_valid, 1);
      chk($sformatf("sweep_pass_c%0d", i), a_out_pass, sweep[i].exp_pass);
      chk("sweep_flags", a_out_flags, 4'b0100);
    end
    a_in_valid = 0;
    step();
    chk("sweep_pass_cnt", a_pass_cnt, 8);
    chk("sweep_fail_cnt", a_fail_cnt, 8);
    chk("sweep_drained", a_out_valid, 0);

    // forwarding: bank1 written in the accept cycle
    a_wr_en = 1; a_wr_bank = 1; a_wr_data = 4'b1000;
    a_in_valid = 1; a_in_cond = 4'd4; a_in_bank = 1;
    step();
    a_wr_en = 0; a_in_valid = 0;
    chk("fwd_pass", a_out_pass, 1);
    chk("fwd_flags", a_out_flags, 4'b1000);
    step();
    chk("fwd_pass_cnt", a_pass_cnt, 9);

    // backpressure
    a_in_valid = 1; a_in_cond = 4'd14; a_in_bank = 0;
    step();
    a_out_ready = 0; a_in_cond = 4'd15;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", a_in_ready, 0);
      step();
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_out_pass", a_out_pass, 1);
      chk("bp_out_flags", a_out_flags, 4'b0100);
      chk("bp_pass_cnt", a_pass_cnt, 9);
    end
    a_in_valid = 0; a_out_ready = 1;
    #1 chk("bp_in_ready_rise", a_in_ready, 1);
    step();
    chk("bp_pass_cnt_inc", a_pass_cnt, 10);
    chk("bp_fail_cnt", a_fail_cnt, 8);
    chk("bp_drained", a_out_valid, 0);

    // flush of a buffered pass result
    a_in_valid = 1; a_in_cond = 4'd14;
    step();
    a_in_valid = 0; a_out_ready = 0;
    chk("fl_full", a_out_valid, 1);
    a_flush = 1; a_in_valid = 1;
    #1 chk("fl_in_ready", a_in_ready, 0);
    step();
    a_flush = 0; a_in_valid = 0;
    chk("fl_out_valid", a_out_valid, 0);
    chk("fl_pass_cnt", a_pass_cnt, 10);
    a_out_ready = 1;
    step();
    chk("fl_pass_cnt_after", a_pass_cnt, 10);

    // reset mid-transaction
    a_in_valid = 1; a_in_cond = 4'd14; a_out_ready = 0;
    step();
    a_in_valid = 0;
    rst = 1;
    #1 chk("rstmid_out_valid", a_out_valid, 0);
    chk("rstmid_pass_cnt", a_pass_cnt, 0);
    step();
    rst = 0; a_out_ready = 1;
    a_in_valid = 1; a_in_cond = 4'd0; a_in_bank = 0;
    step();
    a_in_valid = 0;
    chk("rstmid_first_valid", a_out_valid, 1);
    chk("rstmid_first_pass", a_out_pass, 0);
    chk("rstmid_first_flags", a_out_flags, 0);

    // saturation on the 2-bit counter instance
    b_out_ready = 1; b_in_valid = 1; b_in_cond = 4'd14; b_in_bank = 0;
    for (int k = 0; k < 5; k++) step();
    b_in_valid = 0;
    step();
    chk("sat_pass_cnt", b_pass_cnt, 3);
    chk("sat_fail_cnt", b_fail_cnt, 0);

    // invalid bank, with a simultaneous (ignored) write to that bank
    b_wr_en = 1; b_wr_bank = 3; b_wr_data = 4'b1111;
    b_in_valid = 1; b_in_cond = 4'd14; b_in_bank = 3;
    step();
    b_wr_en = 0; b_in_valid = 0;
    chk("inv_out_valid", b_out_valid, 1);
    chk("inv_out_pass", b_out_pass, 0);
    chk("inv_out_flags", b_out_flags, 0);
    step();
    chk("inv_fail_cnt", b_fail_cnt, 1);
    b_in_valid = 1; b_in_cond = 4'd1; b_in_bank = 2;
    step();
    b_in_valid = 0;
    chk("inv_bank2_flags", b_out_flags, 0);
    chk("inv_bank2_pass", b_out_pass, 1);

    // randomized run against the reference model
    rst = 1;
    a_wr_en = 0; a_in_valid = 0; a_flush = 0; a_out_ready = 0;
    step();
    rst = 0;
    m_q.delete();
    m_bank[0] = 0; m_bank[1] = 0;
    m_pass = 0; m_fail = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic exp_ready, acc;
      res_t r;
      a_in_valid  = ($urandom % 4) != 0;
      a_in_cond   = 4'($urandom);
      a_in_bank   = 1'($urandom);
      a_wr_en     = ($urandom % 3) == 0;
      a_wr_bank   = 1'($urandom);
      a_wr_data   = 4'($urandom);
      a_out_ready = ($urandom % 3) != 0;
      a_flush     = !a_out_ready && (($urandom % 6) == 0);
      #1;
      exp_ready = !a_flush && (m_q.size() == 0 || a_out_ready);
      chk("rnd_in_ready", a_in_ready, exp_ready);
      acc = a_in_valid && exp_ready;
      if (acc) begin
        r.flags = (a_wr_en && a_wr_bank == a_in_bank) ? a_wr_data : m_bank[a_in_bank];
        r.pass  = ref_pass(a_in_cond, r.flags);
      end
      if (a_flush) m_q.delete();
      else if (m_q.size() > 0 && a_out_ready) begin
        if (m_q[0].pass) m_pass = (m_pass < 65535) ? m_pass + 1 : m_pass;
        else             m_fail = (m_fail < 65535) ? m_fail + 1 : m_fail;
        m_q.pop_front();
      end
      if (acc) m_q.push_back(r);
      if (a_wr_en) m_bank[a_wr_bank] = a_wr_data;
      step();
      chk("rnd_out_valid", a_out_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("rnd_out_pass", a_out_pass, m_q[0].pass);
        chk("rnd_out_flags", a_out_flags, m_q[0].flags);
      end
      chk("rnd_pass_cnt", a_pass_cnt, m_pass);
      chk("rnd_fail_cnt", a_fail_cnt, m_fail);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
